// File: rtl/conv1_accumulator_pkg.sv
// Shared definitions for the conv1 datapath.
// Holds the accumulator word width that the conv1 accumulator and the
// activation stage use, the activation/weight width, the saturation limits
// of the accumulator word, and the accumulator FSM state encoding.
package conv1_accumulator_pkg;

    // Width of the signed accumulator word passed to the activation stage.
    localparam int CONV1_ACC_W  = 20;
    // Width of signed activations and weights.
    localparam int CONV1_ACT_W  = 8;
    // Width of a full pixel x weight product.
    localparam int CONV1_PROD_W = 2 * CONV1_ACT_W;

    // Saturation limits of a CONV1_ACC_W-bit signed word (+524287 / -524288).
    localparam logic signed [CONV1_ACC_W-1:0] SAT_MAX = 20'h7FFFF;
    localparam logic signed [CONV1_ACC_W-1:0] SAT_MIN = 20'h80000;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } conv1_state_e;

endpackage

// File: rtl/conv1_sat_trunc.sv
// Combinational signed saturator from IN_W bits down to OUT_W bits.
// Values above the largest OUT_W-bit signed number clamp to it, values below
// the smallest clamp to it, everything else is truncated unchanged.
// Ports:
//   in_val   input  IN_W   signed wide value
//   out_val  output OUT_W  signed saturated value
module conv1_sat_trunc #(
    parameter int IN_W  = 24,
    parameter int OUT_W = 20
) (
    input  logic signed [IN_W-1:0]  in_val,
    output logic signed [OUT_W-1:0] out_val
);

    // OUT_W-bit signed limits, sign-extended to IN_W bits for comparison.
    localparam logic signed [IN_W-1:0] HI_LIM =
        {{(IN_W-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
    localparam logic signed [IN_W-1:0] LO_LIM =
        {{(IN_W-OUT_W+1){1'b1}}, {(OUT_W-1){1'b0}}};

    always_comb begin
        if (in_val > HI_LIM) begin
            out_val = HI_LIM[OUT_W-1:0];
        end else if (in_val < LO_LIM) begin
            out_val = LO_LIM[OUT_W-1:0];
        end else begin
            out_val = in_val[OUT_W-1:0];
        end
    end

endmodule

// File: rtl/conv1_accumulator.sv
// conv1 window accumulator.
// Sequential MAC: loads a per-channel bias on start, multiplies TAPS signed
// pixel/weight pairs through a one-stage product register, accumulates them
// into an INT_W-bit register that never wraps, and presents one saturated
// ACC_W-bit sum per window to the activation stage.
// Ports:
//   clk, rst             clock, synchronous active-high reset
//   start, bias          begin a window / bias sampled when start is accepted
//   abort                drop the current window (or pending result)
//   in_valid, in_ready   input pair handshake
//   in_pixel, in_weight  signed 8-bit activation and weight
//   out_valid, out_ready output handshake
//   out_sum              signed saturated window sum
//   busy                 high whenever the FSM is not IDLE
//   state_dbg            current FSM state
//
// Handshakes: a transfer happens on a rising edge where valid and ready are
// both high. in_ready depends only on registered state, never on in_valid.
// out_valid/out_sum are registered and stay stable until out_ready is seen.
module conv1_accumulator
    import conv1_accumulator_pkg::*;
#(
    parameter int TAPS  = 9,
    parameter int ACC_W = CONV1_ACC_W,
    parameter int INT_W = 24
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          start,
    input  logic signed [ACC_W-1:0]       bias,
    input  logic                          abort,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic signed [CONV1_ACT_W-1:0] in_pixel,
    input  logic signed [CONV1_ACT_W-1:0] in_weight,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic signed [ACC_W-1:0]       out_sum,
    output logic                          busy,
    output conv1_state_e                  state_dbg
);

    localparam int                CNT_W     = 8;
    localparam logic [CNT_W-1:0]  TAPS_INIT = CNT_W'(TAPS);

    conv1_state_e                    state_q, state_d;
    logic [CNT_W-1:0]                tap_cnt_q, tap_cnt_d;
    logic signed [CONV1_PROD_W-1:0]  prod_q, prod_d;
    logic                            prod_vld_q, prod_vld_d;
    logic signed [INT_W-1:0]         acc_q, acc_d;
    logic signed [ACC_W-1:0]         out_sum_q, out_sum_d;
    logic                            out_valid_q, out_valid_d;

    logic                            in_hs;
    logic                            load_bias;
    logic signed [INT_W-1:0]         bias_ext;
    logic signed [INT_W-1:0]         prod_ext;
    logic signed [ACC_W-1:0]         sat_sum;

    assign in_ready  = (state_q == ACCUM) && (tap_cnt_q != '0);
    assign in_hs     = in_valid & in_ready;
    assign busy      = (state_q != IDLE);
    assign out_valid = out_valid_q;
    assign out_sum   = out_sum_q;
    assign state_dbg = state_q;

    // A new window can open from IDLE, or from DONE in the same cycle the
    // result is taken (back-to-back windows). abort always wins over start.
    assign load_bias = start & ~abort &
                       ((state_q == IDLE) | ((state_q == DONE) & out_ready));

    assign bias_ext = {{(INT_W-ACC_W){bias[ACC_W-1]}}, bias};
    assign prod_ext = {{(INT_W-CONV1_PROD_W){prod_q[CONV1_PROD_W-1]}}, prod_q};

    // Product and accumulate stages. The accumulate stage runs in every
    // state so the final product lands during DRAIN. No handshake can
    // coincide with a bias load, so the two never collide.
    always_comb begin
        prod_d     = prod_q;
        prod_vld_d = in_hs & ~abort;
        acc_d      = acc_q;
        if (in_hs) begin
            prod_d = CONV1_PROD_W'(in_pixel) * CONV1_PROD_W'(in_weight);
        end
        if (load_bias) begin
            acc_d = bias_ext;
        end else if (prod_vld_q) begin
            acc_d = acc_q + prod_ext;
        end
    end

    // The result is saturated from the value the accumulator takes at the
    // end of DRAIN, so it includes the last product.
    conv1_sat_trunc #(
        .IN_W  (INT_W),
        .OUT_W (ACC_W)
    ) u_sat (
        .in_val  (acc_d),
        .out_val (sat_sum)
    );

    // Next-state and output-register logic.
    always_comb begin
        state_d     = state_q;
        tap_cnt_d   = tap_cnt_q;
        out_sum_d   = out_sum_q;
        out_valid_d = out_valid_q;
        case (state_q)
            IDLE: begin
                if (load_bias) begin
                    tap_cnt_d = TAPS_INIT;
                    state_d   = ACCUM;
                end
            end
            ACCUM: begin
                if (abort) begin
                    state_d = IDLE;
                end else if (in_hs) begin
                    tap_cnt_d = tap_cnt_q - 8'd1;
                    if (tap_cnt_q == 8'd1) begin
                        state_d = DRAIN;
                    end
                end
            end
            DRAIN: begin
                if (abort) begin
                    state_d = IDLE;
                end else begin
                    out_sum_d   = sat_sum;
                    out_valid_d = 1'b1;
                    state_d     = DONE;
                end
            end
            DONE: begin
                if (abort) begin
                    out_valid_d = 1'b0;
                    state_d     = IDLE;
                end else if (out_ready) begin
                    out_valid_d = 1'b0;
                    if (load_bias) begin
                        tap_cnt_d = TAPS_INIT;
                        state_d   = ACCUM;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            tap_cnt_q   <= '0;
            prod_q      <= '0;
            prod_vld_q  <= 1'b0;
            acc_q       <= '0;
            out_sum_q   <= '0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            tap_cnt_q   <= tap_cnt_d;
            prod_q      <= prod_d;
            prod_vld_q  <= prod_vld_d;
            acc_q       <= acc_d;
            out_sum_q   <= out_sum_d;
            out_valid_q <= out_valid_d;
        end
    end

endmodule
